kgp_mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the next-generation KGP mini-RISC core. It replaces the single-cycle control path. An FSM steps each instruction through fetch, decode, execute, memory and write-back. Instruction and data memory accesses use a req/ack handshake, so the core tolerates memory with variable latency, and a stalled access raises a sticky fault after a timeout. The block sits between the instruction decoder (which supplies an instruction class) and the datapath (which consumes the per-cycle enables).

---
 rtl/kgp_mc_sequencer_pkg.sv | 28 ++
 rtl/kgp_mc_sequencer_if.sv | 12 +
 rtl/kgp_mc_sequencer_wait_timer.sv | 22 ++
 rtl/kgp_mc_sequencer.sv | 140 ++++++++++++++
 tb/tb_kgp_mc_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/kgp_mc_sequencer_pkg.sv
// kgp_pkg: shared FSM state and instruction-class encodings for the KGP multi-cycle sequencer
// Contents: state_e (FSM states), cls_e (decoded instruction classes), PC/write-back select constants
package kgp_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_FAULT  = 3'd7
   } state_e;
   typedef enum logic [2:0] {
      CLS_ALU    = 3'd0,
      CLS_ALUI   = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_JUMP   = 3'd5,
      CLS_HALT   = 3'd6,
      CLS_NOP    = 3'd7
   } cls_e;
   localparam logic PC_SEL_SEQ = 1'b0;
   localparam logic PC_SEL_TGT = 1'b1;
   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_MEM = 1'b1;
endpackage

// File: rtl/kgp_mc_sequencer_if.sv
// kgp_mc_sequencer_if: instruction/data memory req/ack bundle
// Signals: imem_req/imem_ack (fetch), dmem_req/dmem_we/dmem_ack (data access)
// Modports: master = sequencer (drives requests), slave = memory (drives acks)
interface kgp_mc_sequencer_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;
   modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
   modport slave (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/kgp_mc_sequencer_wait_timer.sv
// kgp_wait_timer: memory wait-cycle counter with timeout compare
// Ports: clk, rst (async, active-low), clr (restart count), stall (req high, ack low),
//        timeout (this stall cycle is the MEM_TIMEOUT-th consecutive one)
module kgp_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic stall,
   output logic timeout
);
   // cnt_q holds wait cycles already spent; the current stall cycle makes it reach the limit
   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? 8'd0 : stall ? cnt_q + 8'd1 : cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= 8'd0;
      else cnt_q <= cnt_d;
   // an ack clears stall, so an ack in the limit cycle completes the access instead
   assign timeout = stall && (cnt_q == LIMIT);
endmodule

// File: rtl/kgp_mc_sequencer.sv
// kgp_mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP mini-RISC core
// Ports: clk, rst (async, active-low); start, instr_class, br_taken from core;
//        mem (kgp_mc_sequencer_if.master) memory handshakes; ir_load, pc_load, pc_sel, alu_en,
//        reg_write, wb_sel datapath enables; state, halted, fault status; retired, cycles perf counters
// Build option: KGP_PERF_CNT_EN enables the saturating retired/cycles counters (tied to 0 otherwise)
module kgp_mc_sequencer import kgp_pkg::*; #(
   parameter int PC_W        = 32,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [2:0]             instr_class,
   input  logic                   br_taken,
   kgp_mc_sequencer_if.master     mem,
   output logic                   ir_load,
   output logic                   pc_load,
   output logic                   pc_sel,
   output logic                   alu_en,
   output logic                   reg_write,
   output logic                   wb_sel,
   output logic [2:0]             state,
   output logic                   halted,
   output logic                   fault,
   output logic [CNT_W-1:0]       retired,
   output logic [CNT_W-1:0]       cycles
);
   if (PC_W < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_param_chk
      $error("kgp_mc_sequencer: illegal parameter value");
   end
   state_e state_q, state_d;
   cls_e   cls_q, cls_d;
   logic   imem_req, dmem_req, dmem_we;
   logic   stall, timeout;
   // stall is decoded from the registered state so the timer never loops through the next-state logic
   assign stall = (state_q == ST_FETCH && !mem.imem_ack) || (state_q == ST_MEM && !mem.dmem_ack);
   kgp_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_d != state_q),
      .stall   (stall),
      .timeout (timeout)
   );
   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_sel    = PC_SEL_SEQ;
      alu_en    = 1'b0;
      reg_write = 1'b0;
      wb_sel    = WB_SEL_ALU;
      halted    = 1'b0;
      fault     = 1'b0;
      case (state_q)
         ST_IDLE: state_d = start ? ST_FETCH : ST_IDLE;
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_load  = mem.imem_ack;
            pc_load  = mem.imem_ack;
            state_d  = mem.imem_ack ? ST_DECODE : timeout ? ST_FAULT : ST_FETCH;
         end
         ST_DECODE: begin
            cls_d   = cls_e'(instr_class);
            state_d = (instr_class == CLS_NOP) ? ST_FETCH : (instr_class == CLS_HALT) ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            alu_en = 1'b1;
            case (cls_q)
               CLS_ALU, CLS_ALUI:   state_d = ST_WB;
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               CLS_BRANCH: begin
                  pc_load = br_taken;
                  pc_sel  = br_taken ? PC_SEL_TGT : PC_SEL_SEQ;
                  state_d = ST_FETCH;
               end
               CLS_JUMP: begin
                  pc_load = 1'b1;
                  pc_sel  = PC_SEL_TGT;
                  state_d = ST_WB;
               end
               default: state_d = ST_FAULT;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls_q == CLS_STORE);
            state_d  = mem.dmem_ack ? ((cls_q == CLS_STORE) ? ST_FETCH : ST_WB) : timeout ? ST_FAULT : ST_MEM;
         end
         ST_WB: begin
            reg_write = 1'b1;
            wb_sel    = (cls_q == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
            state_d   = ST_FETCH;
         end
         ST_HALT: halted = 1'b1;
         default: fault = 1'b1;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= ST_IDLE;
         cls_q   <= CLS_ALU;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
      end
   assign mem.imem_req = imem_req;
   assign mem.dmem_req = dmem_req;
   assign mem.dmem_we  = dmem_we;
   assign state        = state_q;
`ifdef KGP_PERF_CNT_EN
   logic [CNT_W-1:0] retired_q, retired_d, cycles_q, cycles_d;
   logic             retire, active;
   always_comb begin
      // completion points: leaving WB, STORE ack, BRANCH resolve, NOP decode
      retire    = (state_q == ST_WB) || (state_q == ST_MEM && mem.dmem_ack && cls_q == CLS_STORE) ||
                  (state_q == ST_EXEC && cls_q == CLS_BRANCH) || (state_q == ST_DECODE && instr_class == CLS_NOP);
      active    = !(state_q inside {ST_IDLE, ST_HALT, ST_FAULT});
      retired_d = (retire && !(&retired_q)) ? retired_q + CNT_W'(1) : retired_q;
      cycles_d  = (active && !(&cycles_q)) ? cycles_q + CNT_W'(1) : cycles_q;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         retired_q <= '0;
         cycles_q  <= '0;
      end else begin
         retired_q <= retired_d;
         cycles_q  <= cycles_d;
      end
   assign retired = retired_q;
   assign cycles  = cycles_q;
`else
   assign retired = '0;
   assign cycles  = '0;
`endif
endmodule

// File: tb/tb_kgp_mc_sequencer.sv
// tb_kgp_mc_sequencer: directed self-checking bench for kgp_mc_sequencer
module tb_kgp_mc_sequencer;
   import kgp_pkg::*;
`ifdef KGP_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  instr_class;
   logic        br_taken;
   logic        ir_load, pc_load, pc_sel, alu_en, reg_write, wb_sel, halted, fault;
   logic [2:0]  state;
   logic [31:0] retired, cycles;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          ret_exp = 0;
   int          cyc_exp = 0;
   kgp_mc_sequencer_if mif ();
   kgp_mc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .instr_class (instr_class),
      .br_taken    (br_taken),
      .mem         (mif),
      .ir_load     (ir_load),
      .pc_load     (pc_load),
      .pc_sel      (pc_sel),
      .alu_en      (alu_en),
      .reg_write   (reg_write),
      .wb_sel      (wb_sel),
      .state       (state),
      .halted      (halted),
      .fault       (fault),
      .retired     (retired),
      .cycles      (cycles)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check_cnt(input string tag);
      check({tag, " retired"}, 64'(retired), PERF ? 64'(ret_exp) : 64'd0);
      check({tag, " cycles"}, 64'(cycles), PERF ? 64'(cyc_exp) : 64'd0);
   endtask
   // Runs one instruction from its first FETCH cycle. The memory answers a request after iw/dw
   // wait cycles. seq lists the expected state per cycle (one hex digit each); sig holds the
   // expected number of cycles each control is high:
   // {imem_req, ir_load, pc_load, pc_sel, alu_en, reg_write, wb_sel, dmem_req, dmem_we}
   task automatic run_instr(input string tag, input logic [2:0] cls, input logic br, input int iw,
                            input int dw, input int len, input logic [95:0] seq,
                            input logic [35:0] sig, input int retires);
      int          ic = 0;
      int          dc = 0;
      logic [35:0] got = '0;
      instr_class = cls;
      br_taken    = br;
      for (int i = 0; i < len; i++) begin
         mif.imem_ack = mif.imem_req && (ic == iw);
         mif.dmem_ack = mif.dmem_req && (dc == dw);
         #1;
         check($sformatf("%s state[%0d]", tag, i), 64'(state), 64'(seq[4*(len-1-i) +: 3]));
         got = got + {3'b0, mif.imem_req, 3'b0, ir_load, 3'b0, pc_load, 3'b0, pc_sel, 3'b0, alu_en,
                      3'b0, reg_write, 3'b0, wb_sel, 3'b0, mif.dmem_req, 3'b0, mif.dmem_we};
         ic += int'(mif.imem_req);
         dc += int'(mif.dmem_req);
         @(posedge clk);
         #1;
      end
      mif.imem_ack = 1'b0;
      mif.dmem_ack = 1'b0;
      check({tag, " pulses"}, 64'(got), 64'(sig));
      ret_exp += retires;
      cyc_exp += len;
      check_cnt(tag);
   endtask
   function automatic logic [10:0] outs();
      return {mif.imem_req, mif.dmem_req, mif.dmem_we, ir_load, pc_load, pc_sel, alu_en,
              reg_write, wb_sel, halted, fault};
   endfunction
   initial begin
      rst          = 1'b0;
      start        = 1'b0;
      instr_class  = 3'd0;
      br_taken     = 1'b0;
      mif.imem_ack = 1'b0;
      mif.dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset state", 64'(state), 64'd0);
      check("reset outs", 64'(outs()), 64'd0);
      check_cnt("reset");
      rst          = 1'b1;
      mif.imem_ack = 1'b1;
      mif.dmem_ack = 1'b1;
      tick();
      check("idle ack ignored", 64'(state), 64'd0);
      check("idle outs", 64'(outs()), 64'd0);
      mif.imem_ack = 1'b0;
      mif.dmem_ack = 1'b0;
      start        = 1'b1;
      tick();
      start        = 1'b0;
      run_instr("alu",      CLS_ALU,    1'b0, 0,  0, 4,  96'h1235,          36'h111011000, 1);
      run_instr("alui_iw1", CLS_ALUI,   1'b0, 1,  0, 5,  96'h11235,         36'h211011000, 1);
      run_instr("load_dw3", CLS_LOAD,   1'b0, 0,  3, 8,  96'h12344445,      36'h111011140, 1);
      run_instr("store",    CLS_STORE,  1'b0, 0,  0, 4,  96'h1234,          36'h111010011, 1);
      run_instr("store_dw2",CLS_STORE,  1'b0, 0,  2, 6,  96'h123444,        36'h111010033, 1);
      run_instr("br_taken", CLS_BRANCH, 1'b1, 0,  0, 3,  96'h123,           36'h112110000, 1);
      run_instr("br_not",   CLS_BRANCH, 1'b0, 0,  0, 3,  96'h123,           36'h111010000, 1);
      run_instr("jump",     CLS_JUMP,   1'b0, 0,  0, 4,  96'h1235,          36'h112111000, 1);
      run_instr("nop",      CLS_NOP,    1'b0, 0,  0, 2,  96'h12,            36'h111000000, 1);
      run_instr("load",     CLS_LOAD,   1'b0, 0,  0, 5,  96'h12345,         36'h111011110, 1);
      run_instr("alu_iw14", CLS_ALU,    1'b0, 14, 0, 18, 96'h111_111_111_111_111_235, 36'hF11011000, 1);
      run_instr("load_dw14",CLS_LOAD,   1'b0, 0, 14, 19, 96'h123_444_444_444_444_444_5, 36'h1110111F0, 1);
      run_instr("halt",     CLS_HALT,   1'b0, 0,  0, 2,  96'h12,            36'h111000000, 0);
      check("halt state", 64'(state), 64'd6);
      check("halted", 64'(outs()), 64'h002);
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      check("halt absorbs start", 64'(state), 64'd6);
      check_cnt("halt frozen");
      rst = 1'b0;
      #1;
      rst = 1'b1;
      check("halt reset", 64'(state), 64'd0);
      tick();
      start        = 1'b1;
      tick();
      start        = 1'b0;
      instr_class  = CLS_STORE;
      mif.imem_ack = 1'b1;
      tick();
      mif.imem_ack = 1'b0;
      tick();
      tick();
      check("mid-mem state", 64'(state), 64'd4);
      check("mid-mem req", 64'({mif.dmem_req, mif.dmem_we}), 64'd3);
      #2;
      rst = 1'b0;
      #1;
      check("async rst req", 64'({mif.imem_req, mif.dmem_req, mif.dmem_we}), 64'd0);
      check("async rst state", 64'(state), 64'd0);
      ret_exp = 0;
      cyc_exp = 0;
      check_cnt("async rst");
      #1;
      rst = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         check($sformatf("timeout wait[%0d]", i), 64'({state, mif.imem_req}), 64'({3'd1, 1'b1}));
         tick();
      end
      check("timeout fault", 64'(outs()), 64'h001);
      check("timeout state", 64'(state), 64'd7);
      start        = 1'b1;
      mif.imem_ack = 1'b1;
      repeat (3) tick();
      start        = 1'b0;
      mif.imem_ack = 1'b0;
      check("fault absorbs", 64'({state, fault}), 64'({3'd7, 1'b1}));
      cyc_exp = 15;
      check_cnt("fault frozen");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
